snoop_mem_responder: RTL and testbench

SNOOP_MEM_RESPONDER -- requirements
Module: snoop_mem_responder

---
 rtl/snoop_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_snoop_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_mem_responder.sv
// snoop_mem_responder
//
// Memory-side responder on a shared snoop bus. A read_miss from a CPU opens
// a snoop window in which another cache may answer (read_miss_retorno). If
// nobody does, the memory waits out its access latency and drives the line
// back on bus_out until the arbiter grants the bus. Writebacks update the
// 2 x 3-bit line store on any cycle, in any state.
//
// Ports
//   clock      single clock, rising edge
//   reset_n    synchronous active-low reset
//   bus_in     [10] from CPU, [9:8] CPU id, [7] wb valid, [6] wb tag,
//              [5:4] message, [3] tag, [2:0] data
//   bus_grant  arbiter grant; response is consumed when high in RESP
//   bus_out    memory response, same layout as bus_in (zero when not in RESP)
//   busy       high whenever the FSM is not IDLE
//   overrun    one-cycle pulse after a read_miss is dropped
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a read_miss
// SNOOP  | snoop window open; a matching cache reply aborts the request
// ACCESS | memory access latency; aborts are no longer honoured
// RESP   | response on bus_out, held until bus_grant

module snoop_mem_responder #(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned SNOOP_WINDOW = 1,
    parameter logic [2:0]  MEM_INIT0    = 3'b000,
    parameter logic [2:0]  MEM_INIT1    = 3'b000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] bus_in,
    input  logic        bus_grant,
    output logic [10:0] bus_out,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] MSG_RETORNO   = 2'b01;
    localparam logic [1:0] MSG_READ_MISS = 2'b11;

    localparam logic [2:0] SNOOP_LOAD = 3'(SNOOP_WINDOW);
    localparam logic [2:0] LAT_LOAD   = 3'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  cap_id;
    logic        cap_tag;
    logic        resp_valid;
    logic [2:0]  mem [2];

    logic        in_from_cpu;
    logic [1:0]  in_id;
    logic        wb_valid;
    logic        wb_tag;
    logic [1:0]  in_msg;
    logic        in_tag;
    logic [2:0]  in_data;

    logic        is_read_miss;
    logic        is_abort;
    logic        wb_hits_resp;
    logic [2:0]  resp_data;

    assign in_from_cpu = bus_in[10];
    assign in_id       = bus_in[9:8];
    assign wb_valid    = bus_in[7];
    assign wb_tag      = bus_in[6];
    assign in_msg      = bus_in[5:4];
    assign in_tag      = bus_in[3];
    assign in_data     = bus_in[2:0];

    assign is_read_miss = (in_msg == MSG_READ_MISS) && !in_from_cpu;

    // A cache-to-cache reply cancels our request only if it answers the
    // exact requester and line we captured.
    assign is_abort = (in_msg == MSG_RETORNO) && in_from_cpu &&
                      (in_id == cap_id) && (in_tag == cap_tag);

    // A writeback landing on the responded line in a RESP cycle must be seen
    // on the bus that same cycle, so the data field bypasses the store.
    assign wb_hits_resp = wb_valid && (wb_tag == cap_tag);
    assign resp_data    = wb_hits_resp ? in_data : mem[cap_tag];

    assign bus_out = resp_valid ?
                     {1'b0, cap_id, 1'b0, 1'b0, MSG_RETORNO, cap_tag, resp_data} :
                     11'd0;

    // Counters hold the number of cycles left in the current phase,
    // including the present one, so the terminal count is 1: SNOOP lasts
    // SNOOP_WINDOW cycles and ACCESS lasts LATENCY cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            cap_id     <= 2'd0;
            cap_tag    <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            mem[0]     <= MEM_INIT0;
            mem[1]     <= MEM_INIT1;
        end else begin
            if (wb_valid) begin
                mem[wb_tag] <= in_data;
            end

            // Any read_miss outside IDLE is dropped, including the cycle a
            // response is granted.
            overrun <= is_read_miss && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (is_read_miss) begin
                        cap_id  <= in_id;
                        cap_tag <= in_tag;
                        cnt     <= SNOOP_LOAD;
                        busy    <= 1'b1;
                        state   <= ST_SNOOP;
                    end
                end

                ST_SNOOP: begin
                    if (is_abort) begin
                        cnt   <= 3'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt <= 3'd1) begin
                        cnt   <= LAT_LOAD;
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                ST_ACCESS: begin
                    if (cnt <= 3'd1) begin
                        cnt        <= 3'd0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                ST_RESP: begin
                    if (bus_grant) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    cnt        <= 3'd0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_mem_responder.sv
// Bench for snoop_mem_responder. Requests push an expected response (id, tag,
// first RESP cycle) to a scoreboard; a negedge monitor compares bus_out every
// cycle against the scoreboard head and a small memory model.

module tb_snoop_mem_responder;

    localparam int unsigned LATENCY      = 2;
    localparam int unsigned SNOOP_WINDOW = 1;
    localparam logic [2:0]  MEM_INIT0    = 3'b000;
    localparam logic [2:0]  MEM_INIT1    = 3'b000;
    localparam int          LAT_TOT      = SNOOP_WINDOW + LATENCY + 1;

    logic        clock;
    logic        reset_n;
    logic [10:0] bus_in;
    logic        bus_grant;
    logic [10:0] bus_out;
    logic        busy;
    logic        overrun;

    snoop_mem_responder #(
        .LATENCY      (LATENCY),
        .SNOOP_WINDOW (SNOOP_WINDOW),
        .MEM_INIT0    (MEM_INIT0),
        .MEM_INIT1    (MEM_INIT1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_in    (bus_in),
        .bus_grant (bus_grant),
        .bus_out   (bus_out),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] id;
        logic       tag;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    logic [2:0] mdl_mem [2];
    int         tcyc;
    bit         mon_en;
    int         n_tests;
    int         n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, tcyc, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic fc, input logic [1:0] id, input logic wbv,
                                       input logic wbt, input logic [1:0] msg, input logic tag,
                                       input logic [2:0] d);
        return {fc, id, wbv, wbt, msg, tag, d};
    endfunction

    function automatic logic [10:0] rm(input logic [1:0] id, input logic tag);
        return mk(1'b0, id, 1'b0, 1'b0, 2'b11, tag, 3'b000);
    endfunction

    function automatic logic [10:0] wb(input logic tag, input logic [2:0] d);
        return mk(1'b0, 2'b00, 1'b1, tag, 2'b00, 1'b0, d);
    endfunction

    // Drives one cycle of inputs, waits for the edge, updates the memory
    // model with what that edge should have done.
    task automatic step(input logic [10:0] b, input logic g);
        bus_in    = b;
        bus_grant = g;
        @(posedge clock);
        if (!reset_n) begin
            mdl_mem[0] = MEM_INIT0;
            mdl_mem[1] = MEM_INIT1;
        end else if (b[7]) begin
            mdl_mem[b[6]] = b[2:0];
        end
        #1;
        tcyc++;
    endtask

    task automatic push_req(input logic [1:0] id, input logic tag);
        exp_t e;
        e.id  = id;
        e.tag = tag;
        e.cyc = tcyc + LAT_TOT;
        sb.push_back(e);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(11'd0, 1'b1);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                check_eq("out_idle", bus_out, 32'd0);
            end else if (tcyc < sb[0].cyc) begin
                check_eq("out_early", bus_out, 32'd0);
            end else begin
                logic [2:0]  d;
                logic [10:0] exp_w;
                d = (bus_in[7] && bus_in[6] == sb[0].tag) ? bus_in[2:0] : mdl_mem[sb[0].tag];
                exp_w = {1'b0, sb[0].id, 1'b0, 1'b0, 2'b01, sb[0].tag, d};
                check_eq("resp", bus_out, exp_w);
                if (bus_grant) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        tcyc      = 0;
        mon_en    = 1'b0;
        reset_n   = 1'b0;
        bus_in    = 11'd0;
        bus_grant = 1'b1;
        mdl_mem[0] = MEM_INIT0;
        mdl_mem[1] = MEM_INIT1;

        // Reset; a writeback and request during reset must be ignored.
        step(mk(1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 3'b111), 1'b1);
        step(11'd0, 1'b1);
        reset_n = 1'b1;
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_overrun", overrun, 32'd0);
        check_eq("rst_bus_out", bus_out, 32'd0);
        mon_en = 1'b1;

        // Basic read_miss id=10 tag=1, busy high exactly LAT_TOT cycles.
        push_req(2'b10, 1'b1);
        step(rm(2'b10, 1'b1), 1'b1);
        for (int i = 1; i <= LAT_TOT + 1; i++) begin
            check_eq("busy_window", busy, (i <= LAT_TOT) ? 32'd1 : 32'd0);
            step(11'd0, 1'b1);
        end

        // Writeback then read it back.
        step(wb(1'b0, 3'b101), 1'b1);
        push_req(2'b01, 1'b0);
        step(rm(2'b01, 1'b0), 1'b1);
        idles(LAT_TOT + 1);

        // Request and writeback in the same cycle.
        push_req(2'b00, 1'b1);
        step(mk(1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 3'b110), 1'b1);
        idles(LAT_TOT + 1);

        // Snoop abort by matching cache reply.
        step(rm(2'b11, 1'b0), 1'b1);
        check_eq("abort_busy_snoop", busy, 32'd1);
        step(mk(1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 3'b000), 1'b1);
        check_eq("abort_busy_low", busy, 32'd0);
        idles(LAT_TOT + 1);

        // Non-matching reply (wrong id) does not abort.
        push_req(2'b01, 1'b1);
        step(rm(2'b01, 1'b1), 1'b1);
        step(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000), 1'b1);
        idles(LAT_TOT + 1);

        // Grant withheld 5 RESP cycles: response held, then released.
        push_req(2'b01, 1'b1);
        step(rm(2'b01, 1'b1), 1'b0);
        for (int i = 0; i < LAT_TOT - 1 + 5; i++) step(11'd0, 1'b0);
        check_eq("stall_busy", busy, 32'd1);
        step(11'd0, 1'b1);
        check_eq("stall_release_busy", busy, 32'd0);
        check_eq("stall_release_out", bus_out, 32'd0);
        idles(2);

        // Writeback forwarding into RESP.
        push_req(2'b10, 1'b0);
        step(rm(2'b10, 1'b0), 1'b0);
        for (int i = 0; i < LAT_TOT - 1; i++) step(11'd0, 1'b0);
        step(wb(1'b0, 3'b011), 1'b0);
        step(11'd0, 1'b0);
        step(wb(1'b1, 3'b110), 1'b1);
        idles(2);

        // Overrun in ACCESS, then overrun in the granted RESP cycle.
        push_req(2'b00, 1'b1);
        step(rm(2'b00, 1'b1), 1'b1);
        check_eq("ovr_quiet", overrun, 32'd0);
        step(11'd0, 1'b1);
        step(rm(2'b11, 1'b0), 1'b1);
        check_eq("ovr_access_pulse", overrun, 32'd1);
        check_eq("ovr_access_busy", busy, 32'd1);
        step(11'd0, 1'b1);
        check_eq("ovr_access_end", overrun, 32'd0);
        step(rm(2'b01, 1'b0), 1'b1);
        check_eq("ovr_grant_pulse", overrun, 32'd1);
        check_eq("ovr_grant_busy", busy, 32'd0);
        step(11'd0, 1'b1);
        check_eq("ovr_grant_end", overrun, 32'd0);
        check_eq("ovr_grant_idle", busy, 32'd0);
        idles(2);

        // Reset mid-ACCESS after writeback to tag 1.
        step(wb(1'b1, 3'b111), 1'b1);
        push_req(2'b10, 1'b1);
        step(rm(2'b10, 1'b1), 1'b1);
        step(11'd0, 1'b1);
        step(11'd0, 1'b1);
        reset_n = 1'b0;
        step(mk(1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 3'b111), 1'b1);
        sb.delete();
        reset_n = 1'b1;
        check_eq("mid_rst_busy", busy, 32'd0);
        check_eq("mid_rst_overrun", overrun, 32'd0);
        check_eq("mid_rst_out", bus_out, 32'd0);
        step(11'd0, 1'b1);
        check_eq("mid_rst_no_req", busy, 32'd0);
        push_req(2'b01, 1'b1);
        step(rm(2'b01, 1'b1), 1'b1);
        idles(LAT_TOT + 1);
        push_req(2'b10, 1'b0);
        step(rm(2'b10, 1'b0), 1'b1);
        idles(LAT_TOT + 1);

        idles(3);
        check_eq("sb_drain", sb.size(), 32'd0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
